// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
//
// Four-input interrupt controller sitting between the bus peripherals and the
// processor. Rising edges on the peripheral raise lines are captured in a
// pending register. A processor-writable mask and fixed priority (bit 0
// highest) then pick one request at a time, which is presented to the CPU with
// its source ID. The CPU acknowledge is returned to the originating peripheral
// as a single-cycle pulse.
//
// Register window (Base = IntCtrlBaseAddr):
//   Base+0  MASK     R/W   bits [3:0], 1 = source enabled
//   Base+1  PENDING  R/W1C bits [3:0]
//   Base+2  STATUS   RO    {CPU_INTERRUPT, 5'b0, CPU_INTERRUPT_ID}
//
// Ports:
//   CLK                in     system clock
//   RESET              in     synchronous, active-high reset
//   BUS_DATA           inout  shared data bus, driven only on reads of this block
//   BUS_ADDR           in     bus address
//   BUS_WE             in     bus write enable
//   IRQ_RAISE          in     per-source raise lines, bit 0 highest priority
//   IRQ_ACK            out    per-source one-cycle acknowledge pulses
//   CPU_INTERRUPT      out    request to the processor
//   CPU_INTERRUPT_ID   out    index of the source being requested
//   CPU_INTERRUPT_ACK  in     processor acknowledge
// ----------------------------------------------------------------------------
module interrupt_controller #(
   parameter logic [7:0] IntCtrlBaseAddr = 8'hF0,
   parameter logic [3:0] InitialMask     = 4'hF
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [3:0] IRQ_RAISE,
   output logic [3:0] IRQ_ACK,
   output logic       CPU_INTERRUPT,
   output logic [1:0] CPU_INTERRUPT_ID,
   input  logic       CPU_INTERRUPT_ACK
);

   localparam int unsigned NumSrc  = 4;
   localparam int unsigned IdW     = 2;
   localparam int unsigned DataW   = 8;
   localparam int unsigned NumRegs = 3;

   localparam logic [1:0] OffMask    = 2'd0;
   localparam logic [1:0] OffPending = 2'd1;
   localparam logic [1:0] OffStatus  = 2'd2;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REQUEST     = 2'd1,
      ACKNOWLEDGE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [NumSrc-1:0]   raise_q;
   logic [NumSrc-1:0]   pending_q, pending_d;
   logic [NumSrc-1:0]   mask_q, mask_d;
   logic [NumSrc-1:0]   irq_ack_q, irq_ack_d;
   logic [IdW-1:0]      id_q, id_d;
   logic                cpu_int_q, cpu_int_d;
   logic                rd_sel_q, rd_sel_d;
   logic [1:0]          rd_off_q, rd_off_d;

   logic [DataW-1:0]    bus_off_c;
   logic                bus_hit_c;
   logic                wr_mask_c;
   logic                wr_pend_c;
   logic [NumSrc-1:0]   rise_c;
   logic [NumSrc-1:0]   active_c;
   logic [NumSrc-1:0]   w1c_clr_c;
   logic [NumSrc-1:0]   ack_clr_c;
   logic [IdW-1:0]      sel_id_c;
   logic [DataW-1:0]    rd_data_c;
   logic                unused_bus_hi;

   // Address decode; the subtraction keeps the window check free of overflow.
   assign bus_off_c = BUS_ADDR - IntCtrlBaseAddr;
   assign bus_hit_c = (bus_off_c < DataW'(NumRegs));
   assign wr_mask_c = bus_hit_c & BUS_WE & (bus_off_c[1:0] == OffMask);
   assign wr_pend_c = bus_hit_c & BUS_WE & (bus_off_c[1:0] == OffPending);

   // Only the low nibble of a write carries register data.
   assign unused_bus_hi = ^BUS_DATA[7:4];

   // Edge detect and source selection.
   assign rise_c    = IRQ_RAISE & ~raise_q;
   assign active_c  = pending_q & mask_q;
   assign w1c_clr_c = wr_pend_c ? BUS_DATA[NumSrc-1:0] : '0;

   // Lowest set index of the enabled pending sources wins.
   always_comb begin
      sel_id_c = '0;
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (active_c[i]) begin
            sel_id_c = IdW'(i);
         end
      end
   end

   // FSM next-state and registered-output next values.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      cpu_int_d = 1'b0;
      irq_ack_d = '0;
      ack_clr_c = '0;
      case (state_q)
         IDLE: begin
            if (|active_c) begin
               state_d   = REQUEST;
               id_d      = sel_id_c;
               cpu_int_d = 1'b1;
            end
         end
         REQUEST: begin
            // Held regardless of later mask changes, W1C or higher arrivals.
            cpu_int_d = 1'b1;
            if (CPU_INTERRUPT_ACK) begin
               state_d         = ACKNOWLEDGE;
               cpu_int_d       = 1'b0;
               irq_ack_d[id_q] = 1'b1;
               ack_clr_c[id_q] = 1'b1;
            end
         end
         ACKNOWLEDGE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register updates; a same-cycle rise beats any clear.
   always_comb begin
      pending_d = (pending_q & ~(w1c_clr_c | ack_clr_c)) | rise_c;
      mask_d    = wr_mask_c ? BUS_DATA[NumSrc-1:0] : mask_q;
      rd_sel_d  = bus_hit_c & ~BUS_WE;
      rd_off_d  = bus_off_c[1:0];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         raise_q   <= '0;
         pending_q <= '0;
         mask_q    <= InitialMask;
         irq_ack_q <= '0;
         id_q      <= '0;
         cpu_int_q <= 1'b0;
         rd_sel_q  <= 1'b0;
         rd_off_q  <= '0;
      end else begin
         state_q   <= state_d;
         raise_q   <= IRQ_RAISE;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         irq_ack_q <= irq_ack_d;
         id_q      <= id_d;
         cpu_int_q <= cpu_int_d;
         rd_sel_q  <= rd_sel_d;
         rd_off_q  <= rd_off_d;
      end
   end

   // Read data comes only from registered select/offset and register state.
   always_comb begin
      rd_data_c = '0;
      case (rd_off_q)
         OffMask:    rd_data_c = {4'b0, mask_q};
         OffPending: rd_data_c = {4'b0, pending_q};
         OffStatus:  rd_data_c = {cpu_int_q, 5'b0, id_q};
         default:    rd_data_c = '0;
      endcase
   end

   assign BUS_DATA         = rd_sel_q ? rd_data_c : 8'hZZ;
   assign IRQ_ACK          = irq_ack_q;
   assign CPU_INTERRUPT    = cpu_int_q;
   assign CPU_INTERRUPT_ID = id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed bench for interrupt_controller. Inputs change and outputs are
// sampled 1 ns after each rising CLK edge. BUS_DATA carries weak pull-ups so a
// released bus reads back as 8'hFF, a value no register read can produce.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_interrupt_controller;

   localparam logic [7:0] Base = 8'hF0;

   logic       CLK = 1'b0;
   logic       RESET;
   wire  [7:0] BUS_DATA;
   logic [7:0] BUS_ADDR;
   logic       BUS_WE;
   logic [3:0] IRQ_RAISE;
   logic [3:0] IRQ_ACK;
   logic       CPU_INTERRUPT;
   logic [1:0] CPU_INTERRUPT_ID;
   logic       CPU_INTERRUPT_ACK;

   logic       tb_drive;
   logic [7:0] tb_data;

   int tests = 0;
   int fails = 0;

   assign BUS_DATA = tb_drive ? tb_data : 8'hZZ;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (BUS_DATA[g]);
   end

   interrupt_controller #(
      .IntCtrlBaseAddr (8'hF0),
      .InitialMask     (4'hF)
   ) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .BUS_DATA          (BUS_DATA),
      .BUS_ADDR          (BUS_ADDR),
      .BUS_WE            (BUS_WE),
      .IRQ_RAISE         (IRQ_RAISE),
      .IRQ_ACK           (IRQ_ACK),
      .CPU_INTERRUPT     (CPU_INTERRUPT),
      .CPU_INTERRUPT_ID  (CPU_INTERRUPT_ID),
      .CPU_INTERRUPT_ACK (CPU_INTERRUPT_ACK)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      BUS_ADDR = addr;
      BUS_WE   = 1'b1;
      tb_data  = data;
      tb_drive = 1'b1;
      tick();
      BUS_WE   = 1'b0;
      tb_drive = 1'b0;
      BUS_ADDR = 8'h00;
   endtask

   // Address phase, sample the data phase, then one idle cycle to release.
   task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
      BUS_ADDR = addr;
      BUS_WE   = 1'b0;
      tick();
      data     = BUS_DATA;
      BUS_ADDR = 8'h00;
      tick();
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL reset_cpu_int got %b want 0", CPU_INTERRUPT); fails++;
      end
      tests++;
      if (CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL reset_id got %0d want 0", CPU_INTERRUPT_ID); fails++;
      end
      tests++;
      if (IRQ_ACK !== 4'b0000) begin
         $display("FAIL reset_irq_ack got %b want 0000", IRQ_ACK); fails++;
      end
      tests++;
      if (BUS_DATA !== 8'hFF) begin
         $display("FAIL reset_bus_released got %h want ff", BUS_DATA); fails++;
      end
      bus_read(Base + 8'd0, rd);
      tests++;
      if (rd !== 8'h0F) begin
         $display("FAIL reset_mask got %h want 0f", rd); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL reset_pending got %h want 00", rd); fails++;
      end
      bus_read(Base + 8'd2, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL reset_status got %h want 00", rd); fails++;
      end
   endtask

   task automatic test_bus_window();
      logic [7:0] rd;
      bus_write(Base + 8'd2, 8'h00);
      bus_write(Base + 8'd3, 8'h00);
      bus_write(8'h10, 8'h00);
      bus_read(Base + 8'd0, rd);
      tests++;
      if (rd !== 8'h0F) begin
         $display("FAIL window_mask_untouched got %h want 0f", rd); fails++;
      end
      bus_read(Base + 8'd3, rd);
      tests++;
      if (rd !== 8'hFF) begin
         $display("FAIL window_outside_read got %h want ff", rd); fails++;
      end
   endtask

   task automatic test_single();
      logic [7:0] rd;
      IRQ_RAISE = 4'b0010;
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL single_early got %b want 0", CPU_INTERRUPT); fails++;
      end
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd1) begin
         $display("FAIL single_req got int=%b id=%0d want int=1 id=1", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      bus_read(Base + 8'd2, rd);
      tests++;
      if (rd !== 8'h81) begin
         $display("FAIL single_status got %h want 81", rd); fails++;
      end
      CPU_INTERRUPT_ACK = 1'b1;
      tick();
      CPU_INTERRUPT_ACK = 1'b0;
      tests++;
      if (CPU_INTERRUPT !== 1'b0 || IRQ_ACK !== 4'b0010) begin
         $display("FAIL single_ack got int=%b ack=%b want int=0 ack=0010", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      tick();
      tests++;
      if (IRQ_ACK !== 4'b0000) begin
         $display("FAIL single_ack_fall got %b want 0000", IRQ_ACK); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL single_pending got %h want 00", rd); fails++;
      end
      IRQ_RAISE = 4'b0000;
      tick();
   endtask

   task automatic test_priority();
      logic [7:0] rd;
      IRQ_RAISE = 4'b1001;
      tick();
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL prio_first got int=%b id=%0d want int=1 id=0", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      CPU_INTERRUPT_ACK = 1'b1;
      tick();
      CPU_INTERRUPT_ACK = 1'b0;
      tests++;
      if (CPU_INTERRUPT !== 1'b0 || IRQ_ACK !== 4'b0001) begin
         $display("FAIL prio_ack0 got int=%b ack=%b want int=0 ack=0001", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b0 || IRQ_ACK !== 4'b0000) begin
         $display("FAIL prio_gap got int=%b ack=%b want int=0 ack=0000", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd3) begin
         $display("FAIL prio_second got int=%b id=%0d want int=1 id=3", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      CPU_INTERRUPT_ACK = 1'b1;
      tick();
      CPU_INTERRUPT_ACK = 1'b0;
      tests++;
      if (IRQ_ACK !== 4'b1000) begin
         $display("FAIL prio_ack3 got %b want 1000", IRQ_ACK); fails++;
      end
      IRQ_RAISE = 4'b0000;
      tick();
      tests++;
      if (IRQ_ACK !== 4'b0000 || CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL prio_done got int=%b ack=%b want int=0 ack=0000", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL prio_pending got %h want 00", rd); fails++;
      end
   endtask

   task automatic test_mask();
      logic [7:0] rd;
      bus_write(Base + 8'd0, 8'h0E);
      IRQ_RAISE = 4'b0001;
      tick();
      tick();
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL mask_blocked got %b want 0", CPU_INTERRUPT); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h01) begin
         $display("FAIL mask_pending got %h want 01", rd); fails++;
      end
      bus_write(Base + 8'd0, 8'h0F);
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL mask_unmask_early got %b want 0", CPU_INTERRUPT); fails++;
      end
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL mask_unmask_req got int=%b id=%0d want int=1 id=0", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      bus_write(Base + 8'd0, 8'h0E);
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL mask_no_withdraw got int=%b id=%0d want int=1 id=0", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      bus_write(Base + 8'd0, 8'h0F);
      CPU_INTERRUPT_ACK = 1'b1;
      tick();
      CPU_INTERRUPT_ACK = 1'b0;
      tests++;
      if (IRQ_ACK !== 4'b0001) begin
         $display("FAIL mask_ack got %b want 0001", IRQ_ACK); fails++;
      end
      IRQ_RAISE = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_w1c();
      logic [7:0] rd;
      bus_write(Base + 8'd0, 8'h0B);
      IRQ_RAISE = 4'b0100;
      tick();
      tick();
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h04) begin
         $display("FAIL w1c_pended got %h want 04", rd); fails++;
      end
      bus_write(Base + 8'd1, 8'h04);
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL w1c_cleared got %h want 00", rd); fails++;
      end
      IRQ_RAISE = 4'b0000;
      tick();
      // Rise lands on the same edge as the clear.
      IRQ_RAISE = 4'b0100;
      bus_write(Base + 8'd1, 8'h04);
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h04) begin
         $display("FAIL w1c_collision got %h want 04", rd); fails++;
      end
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL w1c_masked_int got %b want 0", CPU_INTERRUPT); fails++;
      end
      bus_write(Base + 8'd1, 8'h04);
      IRQ_RAISE = 4'b0000;
      bus_write(Base + 8'd0, 8'h0F);
      tick();
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL w1c_no_stale_req got %b want 0", CPU_INTERRUPT); fails++;
      end
   endtask

   task automatic test_held_rerise();
      logic [7:0] rd;
      IRQ_RAISE = 4'b0001;
      tick();
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL held_req got int=%b id=%0d want int=1 id=0", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
      CPU_INTERRUPT_ACK = 1'b1;
      tick();
      CPU_INTERRUPT_ACK = 1'b0;
      tests++;
      if (IRQ_ACK !== 4'b0001) begin
         $display("FAIL held_ack got %b want 0001", IRQ_ACK); fails++;
      end
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      tests++;
      if (CPU_INTERRUPT !== 1'b0 || IRQ_ACK !== 4'b0000) begin
         $display("FAIL held_no_repend got int=%b ack=%b want int=0 ack=0000", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL held_pending got %h want 00", rd); fails++;
      end
      IRQ_RAISE = 4'b0000;
      tick();
      IRQ_RAISE = 4'b0001;
      tick();
      tick();
      tests++;
      if (CPU_INTERRUPT !== 1'b1 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL rerise_req got int=%b id=%0d want int=1 id=0", CPU_INTERRUPT, CPU_INTERRUPT_ID); fails++;
      end
   endtask

   // Entered with a request outstanding from the previous task.
   task automatic test_reset_mid_request();
      logic [7:0] rd;
      tests++;
      if (CPU_INTERRUPT !== 1'b1) begin
         $display("FAIL rstmid_precond got %b want 1", CPU_INTERRUPT); fails++;
      end
      bus_write(Base + 8'd0, 8'h03);
      RESET     = 1'b1;
      IRQ_RAISE = 4'b0000;
      tick();
      RESET = 1'b0;
      tests++;
      if (CPU_INTERRUPT !== 1'b0 || IRQ_ACK !== 4'b0000 || CPU_INTERRUPT_ID !== 2'd0) begin
         $display("FAIL rstmid_outputs got int=%b ack=%b id=%0d want 0 0000 0", CPU_INTERRUPT, IRQ_ACK, CPU_INTERRUPT_ID); fails++;
      end
      tests++;
      if (BUS_DATA !== 8'hFF) begin
         $display("FAIL rstmid_bus got %h want ff", BUS_DATA); fails++;
      end
      tick();
      tests++;
      if (IRQ_ACK !== 4'b0000 || CPU_INTERRUPT !== 1'b0) begin
         $display("FAIL rstmid_after got int=%b ack=%b want int=0 ack=0000", CPU_INTERRUPT, IRQ_ACK); fails++;
      end
      bus_read(Base + 8'd1, rd);
      tests++;
      if (rd !== 8'h00) begin
         $display("FAIL rstmid_pending got %h want 00", rd); fails++;
      end
      bus_read(Base + 8'd0, rd);
      tests++;
      if (rd !== 8'h0F) begin
         $display("FAIL rstmid_mask got %h want 0f", rd); fails++;
      end
   endtask

   initial begin
      RESET             = 1'b1;
      BUS_ADDR          = 8'h00;
      BUS_WE            = 1'b0;
      IRQ_RAISE         = 4'b0000;
      CPU_INTERRUPT_ACK = 1'b0;
      tb_drive          = 1'b0;
      tb_data           = 8'h00;

      test_reset();
      test_bus_window();
      test_single();
      test_priority();
      test_mask();
      test_w1c();
      test_held_rerise();
      test_reset_mid_request();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Four-input interrupt controller between the bus peripherals (timer, mouse, etc.) and the processor. Each peripheral holds its interrupt-raise line high until it sees an acknowledge pulse. This block edge-detects those lines into a pending register, applies a processor-writable mask and fixed priority, and presents one request at a time to the processor with a source ID. It then routes the processor's acknowledge back to the originating peripheral as a one-cycle pulse.

## Interface
- IntCtrlBaseAddr, 8'hF0: base address of the three-register window (Base+0..Base+2).
- InitialMask, 4'hF: mask register reset value (1 = source enabled).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  reset, synchronous, active-high.
- BUS_DATA  inout  8  shared data bus; driven only during reads of this block, else 8'hZZ.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- IRQ_RAISE  in  4  per-source raise lines from peripherals; bit 0 is highest priority.
- IRQ_ACK  out  4  per-source acknowledge pulses to peripherals.
- CPU_INTERRUPT  out  1  request to the processor.
- CPU_INTERRUPT_ID  out  2  index of the source being requested; stable while CPU_INTERRUPT=1.
- CPU_INTERRUPT_ACK  in  1  processor acknowledge.

## Operation
Register map:
- Base+0 MASK (R/W, bits [3:0]). Write loads BUS_DATA[3:0]. Reads return {4'b0, MASK}.
- Base+1 PENDING (R/W1C). A write clears every bit where BUS_DATA[i]=1. Reads return {4'b0, PENDING}.
- Base+2 STATUS (RO). Reads return {CPU_INTERRUPT, 5'b0, CPU_INTERRUPT_ID}.

Edge detection:
- A registered copy raise_q of IRQ_RAISE is kept.
- rise[i] = IRQ_RAISE[i] & ~raise_q[i].
- PENDING[i] is set on rise[i], regardless of MASK.
- If a set and a clear (W1C write or acknowledge) hit the same bit in the same cycle, the set wins.

FSM states: IDLE, REQUEST, ACKNOWLEDGE.
- **IDLE:** if (PENDING & MASK) != 0, latch ID = lowest set index of (PENDING & MASK). Go to REQUEST. CPU_INTERRUPT=0.
- **REQUEST:** CPU_INTERRUPT=1 and CPU_INTERRUPT_ID=ID.
  - On CPU_INTERRUPT_ACK=1, clear PENDING[ID] and go to ACKNOWLEDGE.
  - Masking, or W1C-clearing, the selected source while in REQUEST does not withdraw the request.
  - A higher-priority arrival does not preempt the current request.
- **ACKNOWLEDGE:** IRQ_ACK[ID]=1 for exactly this one cycle, CPU_INTERRUPT=0. Always go to IDLE next cycle.
- CPU_INTERRUPT_ACK is ignored in IDLE and ACKNOWLEDGE.

Bus read:
- rd_sel is registered: it is set when BUS_ADDR is in Base..Base+2 and BUS_WE=0. The matched offset is registered with it.
- BUS_DATA is driven with the selected register in the cycle after the match, otherwise 8'hZZ.
- Writes to Base+2, and any address outside the window, have no effect.

## Timing
- Reset values:
  - CPU_INTERRUPT=0, CPU_INTERRUPT_ID=0, IRQ_ACK=4'b0000.
  - PENDING=0, raise_q=0, MASK=InitialMask, state=IDLE, rd_sel=0, BUS_DATA=Z.
- Request latency:
  - IRQ_RAISE rise at edge N sets PENDING at edge N+1.
  - Starting from IDLE, CPU_INTERRUPT is high after edge N+2.
- Acknowledge latency:
  - CPU_INTERRUPT_ACK sampled high at edge M drops CPU_INTERRUPT and raises IRQ_ACK[ID] after edge M.
  - IRQ_ACK falls after edge M+1.
- Back-to-back: the minimum gap between CPU_INTERRUPT requests is 2 cycles (ACKNOWLEDGE, then IDLE).
- A source that stays high after its acknowledge is not re-pended; a new rising edge is required.
- A source that re-rises in the same cycle its bit is cleared stays pending.
- MASK writes take effect at the next IDLE evaluation.
- A source pending while masked is serviced once it is unmasked.
- RESET mid-request: all outputs return to reset values on the next edge. No IRQ_ACK is issued.
- All state is in CLK-edge flops. There are no combinational paths from BUS_ADDR to BUS_DATA.

## Test plan
- **Single source:** RESET, then raise IRQ_RAISE[1] at cycle 10.
  - Expect CPU_INTERRUPT=1, ID=1 at cycle 12.
  - ACK at cycle 15 gives IRQ_ACK=4'b0010 for one cycle at cycle 16.
  - PENDING reads 0x00.
- **Priority:** raise bits 3 and 0 in the same cycle.
  - First request is ID=0; after its acknowledge, ID=3 follows within 2 cycles.
  - Each source gets one IRQ_ACK pulse.
- **Mask:** write MASK=4'b1110, then raise bit 0.
  - No CPU_INTERRUPT; PENDING reads 0x01.
  - Write MASK=4'hF: request with ID=0 appears 2 cycles later.
- **W1C and collision:**
  - Pend bit 2 while masked, write Base+1 with 0x04: PENDING reads 0x00.
  - Repeat with a rise on bit 2 in the write cycle: PENDING reads 0x04.
- **Held line and re-rise:**
  - Hold IRQ_RAISE[0] high through and after its acknowledge: only one request occurs.
  - Drop it, raise again: a second request occurs.
- **Reset mid-request:** assert RESET while CPU_INTERRUPT=1.
  - Next cycle: CPU_INTERRUPT=0, IRQ_ACK=0, PENDING=0, MASK reads 0x0F, BUS_DATA=Z.
